// File: rtl/stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// stack_ctrl_if
// Request/response handshake between the control unit and stack_ctrl.
//   req_valid/req_ready : request handshake (req_op: 00 PUSH, 01 POP, 10 LOAD,
//                         11 reserved); req_data carries the push byte or the
//                         new SP value for LOAD.
//   rsp_valid/rsp_ready : response handshake; rsp_data is the popped byte
//                         (0 otherwise), rsp_err flags overflow, underflow
//                         or a reserved op.
// Modports: master = control unit side, slave = stack_ctrl side.
// -----------------------------------------------------------------------------
interface stack_ctrl_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Sequencer for the 8-bit stack pointer register and the stack memory port.
// Takes one PUSH/POP/LOAD request at a time, drives the SP strobes and memory
// strobes in order, then presents a response until it is accepted.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   bus          stack_ctrl_if.slave request/response handshake
//   i_sp_val     current SP register value
//   o_load_sp    SP load strobe, o_sp_in is the load value
//   o_sp_inc     SP increment strobe
//   o_sp_dec     SP decrement strobe
//   o_sp_in      SP load value (0 outside LOAD)
//   o_mem_addr   stack memory address (0 outside PUSH / POP_RD)
//   o_mem_wdata  stack memory write data (0 outside PUSH)
//   o_mem_we     one-cycle write strobe
//   o_mem_re     read strobe, i_mem_rdata valid the following cycle
//   i_mem_rdata  stack memory read data
//
// Optional feature: define STACK_CTRL_BOUNDS_EN to refuse PUSH at STACK_LIMIT
// (overflow) and POP at STACK_TOP (underflow). Without it only the reserved
// op is flagged and the SP register wraps modulo 256.
// -----------------------------------------------------------------------------
module stack_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  stack_ctrl_if.slave        bus,
  input  logic [7:0]         i_sp_val,
  output logic               o_load_sp,
  output logic               o_sp_inc,
  output logic               o_sp_dec,
  output logic [7:0]         o_sp_in,
  output logic [7:0]         o_mem_addr,
  output logic [7:0]         o_mem_wdata,
  output logic               o_mem_we,
  output logic               o_mem_re,
  input  logic [7:0]         i_mem_rdata
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_INC,
    S_POP_RD,
    S_POP_CAP,
    S_LOAD,
    S_RESP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_data;
  logic [7:0] r_rsp_data;
  logic       r_rsp_err;
  logic       w_accept;
  logic       w_overflow;
  logic       w_underflow;
  logic       w_req_err;

`ifdef STACK_CTRL_BOUNDS_EN
  localparam logic [7:0] STACK_TOP   = 8'hFF;
  localparam logic [7:0] STACK_LIMIT = 8'h80;
  assign w_overflow  = (i_sp_val == STACK_LIMIT);
  assign w_underflow = (i_sp_val == STACK_TOP);
`else
  assign w_overflow  = 1'b0;
  assign w_underflow = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // Error decided at accept time from the live SP value; an errored request
  // goes straight to RESP so no strobe is ever issued for it.
  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_op)
      OP_PUSH: w_req_err = w_overflow;
      OP_POP:  w_req_err = w_underflow;
      OP_LOAD: w_req_err = 1'b0;
      default: w_req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_data     <= 8'h00;
      r_rsp_data <= 8'h00;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data     <= bus.req_data;
        r_rsp_data <= 8'h00;
        r_rsp_err  <= w_req_err;
      end else if (r_state == S_POP_CAP) begin
        r_rsp_data <= i_mem_rdata;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_rsp_data <= 8'h00;
        r_rsp_err  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err) begin
            w_next = S_RESP;
          end else begin
            case (bus.req_op)
              OP_PUSH: w_next = S_PUSH;
              OP_POP:  w_next = S_POP_INC;
              default: w_next = S_LOAD;
            endcase
          end
        end
      end
      S_PUSH:    w_next = S_RESP;
      S_POP_INC: w_next = S_POP_RD;
      S_POP_RD:  w_next = S_POP_CAP;
      S_POP_CAP: w_next = S_RESP;
      S_LOAD:    w_next = S_RESP;
      S_RESP:    if (bus.rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes and their data are pure decodes of the state, so an asynchronous
  // reset drops them immediately.
  always_comb begin
    o_load_sp   = 1'b0;
    o_sp_inc    = 1'b0;
    o_sp_dec    = 1'b0;
    o_sp_in     = 8'h00;
    o_mem_addr  = 8'h00;
    o_mem_wdata = 8'h00;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    case (r_state)
      S_PUSH: begin
        // Write uses the pre-decrement SP; the decrement lands on this edge.
        o_mem_we    = 1'b1;
        o_mem_addr  = i_sp_val;
        o_mem_wdata = r_data;
        o_sp_dec    = 1'b1;
      end
      S_POP_INC: o_sp_inc = 1'b1;
      S_POP_RD: begin
        o_mem_re   = 1'b1;
        o_mem_addr = i_sp_val;
      end
      S_LOAD: begin
        o_load_sp = 1'b1;
        o_sp_in   = r_data;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the 8-bit stack pointer register and stack memory port. Accepts one PUSH, POP or LOAD request at a time over a valid/ready handshake. Drives the SP register's LOAD_SP/SP_INC/SP_DEC strobes and the memory read/write strobes in the correct order, then returns a result with a valid/ready handshake. Sits between the control unit and the SP register/data memory, and is the only block that drives the SP strobes.

## Interface
- STACK_TOP, 8'hFF: empty-stack SP value; must equal the SP register reset value.
- STACK_LIMIT, 8'h80: lowest SP value; push refused when sp_val == STACK_LIMIT; capacity = STACK_TOP − STACK_LIMIT.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_op  in  2  00 PUSH, 01 POP, 10 LOAD, 11 reserved (error).
- req_data  in  8  push data or new SP value for LOAD.
- req_ready  out  1  high only in IDLE.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  popped byte (POP); 0 otherwise.
- rsp_err  out  1  overflow, underflow or reserved op.
- sp_val  in  8  current SP register output.
- LOAD_SP, SP_INC, SP_DEC  out  1 each  SP strobes; at most one high in any cycle.
- sp_in  out  8  SP load value; valid while LOAD_SP is high.
- mem_addr  out  8  stack memory address.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe, one cycle.
- mem_re  out  1  read strobe; mem_rdata valid the following cycle.
- mem_rdata  in  8  read data.

## Operation
- States: IDLE, PUSH, POP_INC, POP_RD, POP_CAP, LOAD, RESP.
- IDLE: req_ready=1. On req_valid, register req_op and req_data, then branch:
  - PUSH: overflow if sp_val == STACK_LIMIT, else go to PUSH.
  - POP: underflow if sp_val == STACK_TOP, else go to POP_INC.
  - LOAD: go to LOAD.
  - Op 11, overflow or underflow: go to RESP with the error flag set.
- PUSH: mem_we=1, mem_addr=sp_val, mem_wdata=data, SP_DEC=1 in the same cycle. Memory uses the pre-decrement SP. Next state RESP.
- POP_INC: SP_INC=1. Next state POP_RD.
- POP_RD: mem_re=1, mem_addr=sp_val (already incremented). Next state POP_CAP.
- POP_CAP: capture mem_rdata into rsp_data register. Next state RESP.
- LOAD: LOAD_SP=1, sp_in=data, no bounds check. Next state RESP.
- RESP: rsp_valid=1. Leaves to IDLE on rsp_ready. rsp_data and rsp_err are stable while rsp_valid is high.
- Error responses: rsp_data=0, and no SP or memory strobe is issued for the failed request.
- All strobes are combinational decodes of state and are 0 outside their state.
- Arithmetic: SP is unsigned 8-bit; wrap is handled by the SP register itself and prevented by the bounds checks.

## Timing
- Reset (asynchronous, immediate): state IDLE; req_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0; all strobes 0; sp_in=0; mem_addr=0; mem_wdata=0.
- Latency from the accept edge to rsp_valid: PUSH 2 cycles, POP 4 cycles, LOAD 2 cycles, error 1 cycle.
- Throughput: at most one request in flight. A new request is accepted the cycle after the rsp_valid&&rsp_ready edge.
- rsp_ready asserted before rsp_valid has no effect.
- Reset mid-operation aborts the request: no response is produced, and strobes drop immediately. The SP register is reset by the same signal.

## Configuration
- STACK_CTRL_BOUNDS_EN defined: overflow and underflow checks active as above.
- STACK_CTRL_BOUNDS_EN undefined:
  - No bounds checks; rsp_err only flags op 11.
  - PUSH at STACK_LIMIT and POP at STACK_TOP proceed normally; SP wraps modulo 256 in the SP register.

## Test plan
- PUSH 0xA5 from reset (sp_val=FF) -> mem_we with addr FF/data A5 and SP_DEC in the same cycle; rsp_valid 2 cycles after accept; rsp_err=0; SP=FE.
- POP after that push -> SP_INC, then mem_re at addr FF, then rsp_data=A5, rsp_err=0 at 4 cycles; SP=FF.
- POP at SP=FF with BOUNDS_EN -> rsp_err=1, rsp_data=0, 1-cycle latency, no strobes. Without BOUNDS_EN -> SP_INC issued, SP wraps to 00.
- LOAD 0x81, then PUSH 0x11, then PUSH 0x22 with STACK_LIMIT=80 -> first push writes addr 81; second push sees SP=80, rsp_err=1, no mem_we.
- Hold rsp_ready=0 for 5 cycles after a POP response -> rsp_valid and rsp_data stay stable, req_ready=0; release -> IDLE next cycle.
- Assert reset in POP_RD -> all strobes 0 immediately, no rsp_valid; after release req_ready=1 and SP=FF.
